// File: rtl/bus_split_arbiter.sv
// bus_split_arbiter: round-robin two-master bus arbiter with split-read release and return
module bus_split_arbiter #(
    parameter int NUM_SLAVES = 3,
    parameter int SSEL_W     = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            mreq,
    input  logic [SSEL_W-1:0]     ssel,
    input  logic [NUM_SLAVES-1:0] ssplit,
    output logic [1:0]            mgrant,
    output logic [1:0]            msplit,
    output logic [NUM_SLAVES-1:0] split_grant,
    output logic                  bus_busy
);
    typedef enum logic [1:0] {IDLE, OWN, SPLIT_RET} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, rr_q, rr_d, sp_q, sp_d, smst_q, smst_d, inplace_q, inplace_d;
    logic [SSEL_W-1:0] sslv_q, sslv_d;
    logic [1:0] mgrant_q, mgrant_d, msplit_q, msplit_d, elig;
    logic [NUM_SLAVES-1:0] sg_q, sg_d;
    logic [2**SSEL_W-1:0] ssplit_pad;
    logic win, sel_split, slv_split;
    always_comb begin
        // zero-extend so out-of-range slave indices read as "no split"
        ssplit_pad = '0;
        ssplit_pad[NUM_SLAVES-1:0] = ssplit;
        sel_split = ssplit_pad[ssel];
        slv_split = ssplit_pad[sslv_q];
        elig = mreq & ~{sp_q & smst_q, sp_q & ~smst_q};
        win = elig[rr_q] ? rr_q : ~rr_q;
        state_d = state_q;
        owner_d = owner_q;
        rr_d = rr_q;
        sp_d = sp_q;
        smst_d = smst_q;
        sslv_d = sslv_q;
        inplace_d = inplace_q;
        mgrant_d = mgrant_q;
        msplit_d = msplit_q;
        sg_d = sg_q;
        case (state_q)
            IDLE: begin
                mgrant_d = '0;
                sg_d = '0;
                if (sp_q && mreq[smst_q] && !slv_split) begin
                    state_d = SPLIT_RET;
                    mgrant_d = {smst_q, ~smst_q};
                    sg_d = NUM_SLAVES'(1) << sslv_q;
                    msplit_d = '0;
                end else if (|elig) begin
                    state_d = OWN;
                    owner_d = win;
                    rr_d = ~win;
                    mgrant_d = {win, ~win};
                end
            end
            OWN: begin
                if (!mreq[owner_q]) begin
                    state_d = IDLE;
                    mgrant_d = '0;
                    sg_d = '0;
                    inplace_d = 1'b0;
                end else if (sel_split && !sp_q && !inplace_q) begin
                    state_d = IDLE;
                    sp_d = 1'b1;
                    smst_d = owner_q;
                    sslv_d = ssel;
                    msplit_d = {owner_q, ~owner_q};
                    mgrant_d = '0;
                end else if (sel_split && sp_q) begin
                    inplace_d = 1'b1;
                end else if (inplace_q && !sel_split && sg_q == '0) begin
                    sg_d = NUM_SLAVES'(1) << ssel;
                end
            end
            SPLIT_RET: begin
                if (!mreq[smst_q]) begin
                    state_d = IDLE;
                    mgrant_d = '0;
                    sg_d = '0;
                    sp_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // split master gave up before its return: drop the pending split silently
        if (sp_q && !mreq[smst_q] && state_q != SPLIT_RET) begin
            sp_d = 1'b0;
            msplit_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q <= 1'b0;
            sp_q <= 1'b0;
            smst_q <= 1'b0;
            sslv_q <= '0;
            inplace_q <= 1'b0;
            mgrant_q <= '0;
            msplit_q <= '0;
            sg_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            sp_q <= sp_d;
            smst_q <= smst_d;
            sslv_q <= sslv_d;
            inplace_q <= inplace_d;
            mgrant_q <= mgrant_d;
            msplit_q <= msplit_d;
            sg_q <= sg_d;
        end
    end
    assign mgrant = mgrant_q;
    assign msplit = msplit_q;
    assign split_grant = sg_q;
    assign bus_busy = state_q != IDLE;
endmodule
